collision_event_gen: RTL and testbench



---
 rtl/game_pkg.sv | 25 ++
 rtl/event_channel.sv | 56 +++++
 rtl/collision_event_gen.sv | 69 ++++++
 tb/tb_collision_event_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared sprite sizes, event bit indices, channel states and the bounding-box test.
package game_pkg;
    localparam int D_W = 64;
    localparam int D_H = 64;
    localparam int R_W = 32;
    localparam int R_H = 32;
    localparam int M_W = 8;
    localparam int M_H = 16;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int EV_CRASH = 0;
    localparam int EV_HIT = 1;

    typedef enum logic [1:0] {IDLE, FIRE, HOLD} ch_state_t;

    // Strict overlap of two boxes given by their top-left corners and sizes.
    // The sums are 11 bits wide so a box near the right edge cannot wrap.
    function automatic logic overlap(
        input logic [9:0] ax, input logic [9:0] ay, input int aw, input int ah,
        input logic [9:0] bx, input logic [9:0] by, input int bw, input int bh
    );
        return ({1'b0, ax} < {1'b0, bx} + 11'(bw)) && ({1'b0, bx} < {1'b0, ax} + 11'(aw)) &&
               ({1'b0, ay} < {1'b0, by} + 11'(bh)) && ({1'b0, by} < {1'b0, ay} + 11'(ah));
    endfunction
endpackage

// File: rtl/event_channel.sv
// event_channel: turns a raw overlap level into one pulse per collision episode.
//   clk_22 : game tick clock
//   rst    : asynchronous active-low reset
//   ov_in  : combinational overlap for this channel
//   freeze : game over; forces the channel idle and masks the pulse
//   pulse  : single-cycle event, driven from registered state
module event_channel
    import game_pkg::*;
#(
    parameter int HOLDOFF = 12
) (
    input  logic clk_22,
    input  logic rst,
    input  logic ov_in,
    input  logic freeze,
    output logic pulse
);
    localparam int CW = $clog2(HOLDOFF + 1);

    logic          ov_q;
    ch_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            ov_q  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            ov_q  <= ov_in;
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // HOLD leaves only after the full holdoff and once the sprites separate.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (ov_q) state_n = FIRE;
            FIRE: begin
                cnt_n   = CW'(HOLDOFF - 1);
                state_n = HOLD;
            end
            HOLD: begin
                if (cnt != '0) cnt_n = cnt - 1'b1;
                else if (!ov_q) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (freeze) state_n = IDLE;
    end

    assign pulse = (state == FIRE) && !freeze;
endmodule

// File: rtl/collision_event_gen.sv
// collision_event_gen: collision events, missile-hit count, robot lives and game over.
//   clk_22              : game tick clock (100 MHz / 2^22)
//   rst                 : asynchronous active-low reset
//   d_x/d_y, r_x/r_y,
//   m_x/m_y             : dragon, robot, missile top-left positions
//   d_valid/r_valid/
//   m_valid             : sprite shown / missile in flight
//   evt                 : game event bus, [1] missile hit dragon, [0] robot crashed into dragon
//   hit_cnt             : saturating missile-hit count
//   lives               : remaining robot lives
//   game_over           : sticky once lives reach 0
module collision_event_gen
    import game_pkg::*;
#(
    parameter int HOLDOFF = 12,
    parameter int LIVES   = 3
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic [9:0] d_x,
    input  logic [9:0] d_y,
    input  logic [9:0] r_x,
    input  logic [9:0] r_y,
    input  logic [9:0] m_x,
    input  logic [9:0] m_y,
    input  logic       d_valid,
    input  logic       r_valid,
    input  logic       m_valid,
    output logic [1:0] evt,
    output logic [7:0] hit_cnt,
    output logic [2:0] lives,
    output logic       game_over
);
    logic ov_hit, ov_crash;

    assign ov_hit   = overlap(m_x, m_y, M_W, M_H, d_x, d_y, D_W, D_H) && m_valid && d_valid;
    assign ov_crash = overlap(r_x, r_y, R_W, R_H, d_x, d_y, D_W, D_H) && r_valid && d_valid;

    event_channel #(.HOLDOFF(HOLDOFF)) u_hit (
        .clk_22 (clk_22),
        .rst    (rst),
        .ov_in  (ov_hit),
        .freeze (game_over),
        .pulse  (evt[EV_HIT])
    );

    event_channel #(.HOLDOFF(HOLDOFF)) u_crash (
        .clk_22 (clk_22),
        .rst    (rst),
        .ov_in  (ov_crash),
        .freeze (game_over),
        .pulse  (evt[EV_CRASH])
    );

    // Pulses are already masked by game_over, so the counters freeze with them.
    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            hit_cnt   <= '0;
            lives     <= 3'(LIVES);
            game_over <= 1'b0;
        end else begin
            if (evt[EV_HIT] && hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 1'b1;
            if (evt[EV_CRASH] && lives != 3'd0) begin
                lives <= lives - 1'b1;
                if (lives == 3'd1) game_over <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_collision_event_gen.sv
// tb_collision_event_gen: directed and random checks against a time-based reference model.
module tb_collision_event_gen;
    localparam int HO = 12;
    localparam int LV = 3;

    logic       clk_22 = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] d_x = 10'd100, d_y = 10'd100, r_x = 10'd400, r_y = 10'd400, m_x = 10'd300, m_y = 10'd300;
    logic       d_valid = 1'b0, r_valid = 1'b0, m_valid = 1'b0;
    logic [1:0] evt;
    logic [7:0] hit_cnt;
    logic [2:0] lives;
    logic       game_over;

    collision_event_gen #(.HOLDOFF(HO), .LIVES(LV)) dut (
        .clk_22    (clk_22),
        .rst       (rst),
        .d_x       (d_x),
        .d_y       (d_y),
        .r_x       (r_x),
        .r_y       (r_y),
        .m_x       (m_x),
        .m_y       (m_y),
        .d_valid   (d_valid),
        .r_valid   (r_valid),
        .m_valid   (m_valid),
        .evt       (evt),
        .hit_cnt   (hit_cnt),
        .lives     (lives),
        .game_over (game_over)
    );

    always #5 clk_22 = ~clk_22;

    int total = 0, bad = 0, cyc = 0;
    int n_hit = 0, n_crash = 0, first_hit = -1, t0 = 0, h0 = 0;

    // Reference: per channel an "armed" flag and the cycle of its last pulse.
    bit arm[2];
    int ft[2];
    bit ovq[2];
    bit pl[2];
    int e_hit, e_lives;
    bit e_go;

    function automatic bit ovl(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
        return ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            arm[c] = 1; ft[c] = -1000; ovq[c] = 0; pl[c] = 0;
        end
        e_hit = 0; e_lives = LV; e_go = 0;
    endtask

    task automatic m_edge();
        bit gop, fired;
        bit nov[2];
        gop = e_go;
        if (pl[0] && e_lives > 0) begin
            if (e_lives == 1) e_go = 1;
            e_lives--;
        end
        if (pl[1] && e_hit < 255) e_hit++;
        nov[1] = ovl(m_x, m_y, 8, 16, d_x, d_y, 64, 64) && m_valid && d_valid;
        nov[0] = ovl(r_x, r_y, 32, 32, d_x, d_y, 64, 64) && r_valid && d_valid;
        for (int c = 0; c < 2; c++) begin
            fired = 0;
            if (gop) arm[c] = 1;
            else if (arm[c] && ovq[c]) begin
                fired = 1; arm[c] = 0; ft[c] = cyc;
            end else if (!arm[c] && cyc - 1 >= ft[c] + HO && !ovq[c]) arm[c] = 1;
            pl[c] = fired && !e_go;
            ovq[c] = nov[c];
        end
    endtask

    task automatic tick();
        @(posedge clk_22);
        cyc++;
        m_edge();
        #1;
        chk("evt", 32'(evt), 32'({pl[1], pl[0]}));
        chk("hit_cnt", 32'(hit_cnt), 32'(e_hit));
        chk("lives", 32'(lives), 32'(e_lives));
        chk("game_over", 32'(game_over), 32'(e_go));
        if (evt[1] === 1'b1) begin
            n_hit++;
            if (first_hit < 0) first_hit = cyc - t0;
        end
        if (evt[0] === 1'b1) n_crash++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        m_reset();
        #1;
        chk("rst_evt", 32'(evt), 32'd0);
        chk("rst_hit", 32'(hit_cnt), 32'd0);
        chk("rst_lives", 32'(lives), 32'(LV));
        chk("rst_go", 32'(game_over), 32'd0);
        @(negedge clk_22);
        rst = 1'b1;
    endtask

    initial begin
        m_reset();
        #1;
        hard_reset();

        d_valid = 1; m_x = 130; m_y = 120; m_valid = 1;
        t0 = cyc; n_hit = 0;
        run(40);
        chk("hit_once", 32'(n_hit), 32'd1);
        chk("hit_latency", 32'(first_hit), 32'd2);
        chk("hit_cnt_1", 32'(hit_cnt), 32'd1);

        m_valid = 0; run(20);
        m_x = 164; m_valid = 1; n_hit = 0; run(20);
        chk("touch_no_hit", 32'(n_hit), 32'd0);
        m_valid = 0; run(20);
        m_x = 163; m_valid = 1; run(20);
        chk("edge_hit", 32'(n_hit), 32'd1);
        m_valid = 0; run(20);

        r_x = 90; r_y = 90; n_crash = 0;
        r_valid = 1; run(3);
        r_valid = 0; run(2);
        r_valid = 1; run(3);
        r_valid = 0; run(20);
        chk("crash_holdoff", 32'(n_crash), 32'd1);
        chk("lives_2", 32'(lives), 32'd2);
        r_valid = 1; run(3);
        r_valid = 0; run(20);
        chk("crash_second", 32'(n_crash), 32'd2);
        chk("lives_1", 32'(lives), 32'd1);

        m_x = 130; m_valid = 1; r_valid = 1;
        run(2);
        chk("both_evt", 32'(evt), 32'd3);
        tick();
        chk("both_hit", 32'(hit_cnt), 32'd3);
        chk("both_lives", 32'(lives), 32'd0);
        chk("both_go", 32'(game_over), 32'd1);
        m_valid = 0; r_valid = 0; run(20);
        n_hit = 0; n_crash = 0;
        m_valid = 1; r_valid = 1; run(20);
        chk("go_no_evt", 32'(n_hit + n_crash), 32'd0);
        chk("go_hit_frozen", 32'(hit_cnt), 32'd3);
        m_valid = 0; r_valid = 0;

        hard_reset();
        for (int i = 0; i < 300; i++) begin
            m_valid = 1; run(2);
            m_valid = 0; run(16);
        end
        chk("hit_sat", 32'(hit_cnt), 32'd255);

        hard_reset();
        m_valid = 1; run(2);
        chk("fire_before_rst", 32'(evt), 32'd2);
        #2 rst = 1'b0;
        m_reset();
        #1;
        chk("async_rst_evt", 32'(evt), 32'd0);
        m_valid = 0;
        @(negedge clk_22);
        rst = 1'b1;
        run(3);
        chk("post_rst_lives", 32'(lives), 32'd3);
        chk("post_rst_hit", 32'(hit_cnt), 32'd0);

        hard_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d_x = 10'($urandom_range(80, 140));
                d_y = 10'($urandom_range(80, 140));
                m_x = 10'($urandom_range(60, 220));
                m_y = 10'($urandom_range(60, 220));
                r_x = 10'($urandom_range(40, 220));
                r_y = 10'($urandom_range(40, 220));
                d_valid = ($urandom_range(0, 7) != 0);
                m_valid = ($urandom_range(0, 2) != 0);
                r_valid = ($urandom_range(0, 3) == 0);
            end
            tick();
            if (i == 300 && game_over) hard_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
